// File: rtl/axi_mem_loader.sv
// Boot loader: streams words into DMEM over AXI-Lite writes, then releases the core.
// LOADER_ABORT_ON_ERR_EN: an error response ends the load early and keeps the core in reset.
module axi_mem_loader #(
    parameter int AXI_ADDR_BITS = 32,
    parameter int AXI_DATA_BITS = 32,
    parameter int CNT_BITS      = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       start_i,
    input  logic [AXI_ADDR_BITS-1:0]   base_addr_i,
    input  logic [CNT_BITS-1:0]        num_words_i,
    input  logic [AXI_DATA_BITS-1:0]   s_data_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       cpu_rst_n_o,
    output logic [AXI_ADDR_BITS-1:0]   AWADDR,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [AXI_DATA_BITS-1:0]   WDATA,
    output logic [AXI_DATA_BITS/8-1:0] WSTRB,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY
);

    localparam int STRB_BITS = AXI_DATA_BITS / 8;
    localparam int LSB       = $clog2(STRB_BITS);
    localparam logic [AXI_ADDR_BITS-1:0] WORD_BYTES = AXI_ADDR_BITS'(STRB_BITS);
    localparam logic [AXI_ADDR_BITS-1:0] ADDR_MASK  = ~AXI_ADDR_BITS'((1 << LSB) - 1);
    localparam logic [CNT_BITS-1:0]      CNT_ONE    = CNT_BITS'(1);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RESP, DONE} state_t;

    state_t                   state_q, state_n;
    logic [AXI_ADDR_BITS-1:0] addr_q, addr_n;
    logic [AXI_DATA_BITS-1:0] data_q, data_n;
    logic [CNT_BITS-1:0]      num_q, num_n;
    logic [CNT_BITS-1:0]      count_q, count_n;
    logic                     awvalid_q, awvalid_n;
    logic                     wvalid_q, wvalid_n;
    logic                     err_q, err_n;
    logic                     cpu_rst_n_q, cpu_rst_n_n;
    logic                     bresp_err;
    logic                     last_word;

    assign bresp_err = (BRESP != 2'b00);
    assign last_word = ((count_q + CNT_ONE) == num_q);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            num_q       <= '0;
            count_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            num_q       <= num_n;
            count_q     <= count_n;
            awvalid_q   <= awvalid_n;
            wvalid_q    <= wvalid_n;
            err_q       <= err_n;
            cpu_rst_n_q <= cpu_rst_n_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        data_n      = data_q;
        num_n       = num_q;
        count_n     = count_q;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        err_n       = err_q;
        cpu_rst_n_n = cpu_rst_n_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_n  = base_addr_i & ADDR_MASK;
                    num_n   = num_words_i;
                    count_n = '0;
                    err_n   = 1'b0;
                    state_n = (num_words_i == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (s_valid_i) begin
                    data_n    = s_data_i;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    state_n   = WRITE;
                end
            end
            WRITE: begin
                // AW and W retire independently, in any order
                if (awvalid_q && AWREADY) awvalid_n = 1'b0;
                if (wvalid_q && WREADY)   wvalid_n  = 1'b0;
                if (!awvalid_n && !wvalid_n) state_n = RESP;
            end
            RESP: begin
                if (BVALID) begin
                    if (bresp_err) err_n = 1'b1;
                    count_n = count_q + CNT_ONE;
                    addr_n  = addr_q + WORD_BYTES;
`ifdef LOADER_ABORT_ON_ERR_EN
                    if (bresp_err || last_word) state_n = DONE;
                    else                        state_n = FETCH;
`else
                    state_n = last_word ? DONE : FETCH;
`endif
                end
            end
            DONE: begin
`ifdef LOADER_ABORT_ON_ERR_EN
                // an aborted load leaves the core held in reset
                cpu_rst_n_n = cpu_rst_n_q | ~err_q;
`else
                cpu_rst_n_n = 1'b1;
`endif
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign s_ready_o   = (state_q == FETCH);
    assign BREADY      = (state_q == RESP);
    assign busy_o      = (state_q == FETCH) || (state_q == WRITE) || (state_q == RESP);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign AWADDR      = addr_q;
    assign AWVALID     = awvalid_q;
    assign WDATA       = data_q;
    assign WVALID      = wvalid_q;
    assign WSTRB       = '1;

endmodule

// File: tb/tb_axi_mem_loader.sv
// Bench for axi_mem_loader: stream source, AXI-Lite slave with per-word delays,
// scoreboard of expected address/data pairs.
module tb_axi_mem_loader;

    logic        ACLK, ARESETn, start_i;
    logic [31:0] base_addr_i;
    logic [15:0] num_words_i;
    logic [31:0] s_data_i;
    logic        s_valid_i, s_ready_o, busy_o, done_o, err_o, cpu_rst_n_o;
    logic [31:0] AWADDR, WDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;

    axi_mem_loader dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_words_i(num_words_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cpu_rst_n_o(cpu_rst_n_o),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] sb[$];
    logic [31:0] str_q[$];
    logic [31:0] exp_addr = 0;
    logic [63:0] sb_top;
    int          gap = 0;
    int          gap_cnt = 0;
    logic        s_hs = 0;
    logic        flush = 0;

    int          awd[8];
    int          wd[8];
    logic [1:0]  brs[8];
    int          b_idx = 0;
    int          aw_wait = 0;
    int          w_wait = 0;

    int aw_tot = 0, w_tot = 0, b_tot = 0, sr_tot = 0, done_tot = 0;
    int aw0, b0, sr0, d0;

    logic        aw_got = 0, w_got = 0;
    logic [31:0] aw_cap, w_cap, aw_prev, w_prev;
    logic        aw_pend = 0, w_pend = 0;
    logic        aw_hs_prev = 0, w_hs_prev = 0, done_prev = 0;

    // stream source
    initial begin
        s_valid_i = 1'b0;
        s_data_i  = '0;
        forever begin
            @(posedge ACLK); #1;
            if (s_hs) begin
                s_hs = 1'b0;
                if (str_q.size() > 0) str_q.delete(0);
                gap_cnt = gap;
            end
            if (flush) begin
                str_q.delete();
                gap_cnt   = 0;
                s_valid_i = 1'b0;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
                s_valid_i = 1'b0;
            end else if (str_q.size() > 0) begin
                s_valid_i = 1'b1;
                s_data_i  = str_q[0];
            end else begin
                s_valid_i = 1'b0;
            end
        end
    end

    // AXI-Lite slave with per-word ready delays and responses
    initial begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b00;
        forever begin
            @(posedge ACLK); #1;
            if (AWVALID) begin
                AWREADY = (aw_wait >= awd[b_idx % 8]);
                aw_wait++;
            end else begin
                AWREADY = 1'b0;
                aw_wait = 0;
            end
            if (WVALID) begin
                WREADY = (w_wait >= wd[b_idx % 8]);
                w_wait++;
            end else begin
                WREADY = 1'b0;
                w_wait = 0;
            end
            BVALID = BREADY;
            BRESP  = BREADY ? brs[b_idx % 8] : 2'b00;
        end
    end

    // monitor and scoreboard
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            sb.delete();
            aw_got = 0; w_got = 0;
            aw_pend = 0; w_pend = 0;
            aw_hs_prev = 0; w_hs_prev = 0;
            done_prev = 0;
        end else begin
            if (aw_pend) check("aw_hold", {AWVALID, AWADDR}, {1'b1, aw_prev});
            if (w_pend)  check("w_hold", {WVALID, WDATA}, {1'b1, w_prev});
            if (aw_hs_prev) check("aw_drop", AWVALID, 0);
            if (w_hs_prev)  check("w_drop", WVALID, 0);
            if (done_o) begin
                check("done_pulse", done_prev, 0);
                done_tot++;
            end
            done_prev = done_o;
            if (s_ready_o) sr_tot++;
            if (s_valid_i && s_ready_o) begin
                sb.push_back({exp_addr, s_data_i});
                exp_addr += 32'd4;
                s_hs = 1'b1;
            end
            if (AWVALID && AWREADY) begin
                check("one_outstanding", aw_tot - b_tot, 0);
                aw_tot++;
                aw_cap = AWADDR;
                aw_got = 1'b1;
            end
            if (WVALID && WREADY) begin
                check("wstrb", WSTRB, 4'hF);
                w_tot++;
                w_cap = WDATA;
                w_got = 1'b1;
            end
            if (aw_got && w_got) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    sb_top = sb.pop_front();
                    check("awaddr", aw_cap, sb_top[63:32]);
                    check("wdata", w_cap, sb_top[31:0]);
                end
                aw_got = 1'b0;
                w_got  = 1'b0;
            end
            if (BVALID && BREADY) begin
                b_tot++;
                b_idx++;
            end
            aw_pend    = AWVALID && !AWREADY;
            aw_prev    = AWADDR;
            aw_hs_prev = AWVALID && AWREADY;
            w_pend     = WVALID && !WREADY;
            w_prev     = WDATA;
            w_hs_prev  = WVALID && WREADY;
        end
    end

    task automatic clear_slave();
        for (int i = 0; i < 8; i++) begin
            awd[i] = 0;
            wd[i]  = 0;
            brs[i] = 2'b00;
        end
    endtask

    task automatic do_reset();
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(posedge ACLK);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
    endtask

    task automatic begin_load(input logic [31:0] base, input logic [15:0] num);
        @(posedge ACLK); #1;
        exp_addr = base;
        b_idx = 0;
        aw0 = aw_tot; b0 = b_tot; sr0 = sr_tot; d0 = done_tot;
        start_i = 1'b1;
        base_addr_i = base;
        num_words_i = num;
        @(posedge ACLK); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        logic found;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < max) begin
            @(negedge ACLK);
            cyc++;
            found = done_o;
        end
        check("done_seen", found, 1);
        @(negedge ACLK);
        check("done_low", done_o, 0);
        check("sb_empty", sb.size(), 0);
        check("done_once", done_tot - d0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   cyc;
        logic seen;
        ARESETn = 1'b0;
        start_i = 1'b0;
        base_addr_i = '0;
        num_words_i = '0;
        clear_slave();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_valids", {AWVALID, WVALID, BREADY}, 0);
        check("rst_status", {s_ready_o, busy_o, done_o, err_o}, 0);
        check("rst_cpu", cpu_rst_n_o, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        // empty load
        begin_load(32'h0, 16'd0);
        wait_done(20, cyc);
        check("num0_lat", cyc, 1);
        check("num0_aw", aw_tot - aw0, 0);
        check("num0_sready", sr_tot - sr0, 0);
        check("num0_cpu", cpu_rst_n_o, 1);

        // zero-wait three-word copy
        gap = 0;
        str_q.push_back(32'hA0);
        str_q.push_back(32'hA1);
        str_q.push_back(32'hA2);
        begin_load(32'h100, 16'd3);
        wait_done(100, cyc);
        check("basic_lat", cyc, 10);
        check("basic_aw", aw_tot - aw0, 3);
        check("basic_b", b_tot - b0, 3);
        check("basic_err", err_o, 0);
        check("basic_cpu", cpu_rst_n_o, 1);

        // channel skew and stream gaps
        gap = 2;
        awd[0] = 0; wd[0] = 3;
        awd[1] = 3; wd[1] = 0;
        awd[2] = 2; wd[2] = 2;
        str_q.push_back(32'h1111_0000);
        str_q.push_back(32'h2222_0001);
        str_q.push_back(32'h3333_0002);
        begin_load(32'h2000, 16'd3);
        wait_done(200, cyc);
        check("skew_aw", aw_tot - aw0, 3);
        check("skew_b", b_tot - b0, 3);
        check("skew_err", err_o, 0);

        // error response on the second of four words
        do_reset();
        clear_slave();
        gap = 0;
        brs[1] = 2'b10;
        for (int i = 0; i < 4; i++) str_q.push_back(32'hB0 + i);
        begin_load(32'h400, 16'd4);
        wait_done(200, cyc);
        check("err_set", err_o, 1);
`ifdef LOADER_ABORT_ON_ERR_EN
        check("abort_aw", aw_tot - aw0, 2);
        check("abort_b", b_tot - b0, 2);
        check("abort_left", str_q.size(), 2);
        check("abort_cpu", cpu_rst_n_o, 0);
        flush = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 flush = 1'b0;
`else
        check("err_aw", aw_tot - aw0, 4);
        check("err_b", b_tot - b0, 4);
        check("err_cpu", cpu_rst_n_o, 1);
`endif
        clear_slave();

        // address wrap with a start pulse while busy
        str_q.push_back(32'hC0);
        str_q.push_back(32'hC1);
        begin_load(32'hFFFF_FFFC, 16'd2);
        check("err_clear", err_o, 0);
        repeat (2) @(posedge ACLK);
        #1;
        start_i = 1'b1;
        base_addr_i = 32'h40;
        num_words_i = 16'd5;
        @(posedge ACLK); #1;
        start_i = 1'b0;
        wait_done(100, cyc);
        check("wrap_aw", aw_tot - aw0, 2);
        check("wrap_cpu", cpu_rst_n_o, 1);
        repeat (3) @(negedge ACLK);
        check("wrap_idle", busy_o, 0);
        check("wrap_noextra", aw_tot - aw0, 2);

        // reset in the middle of a write
        awd[0] = 5;
        wd[0]  = 5;
        str_q.push_back(32'hD0);
        begin_load(32'h300, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            seen = AWVALID;
        end
        check("mid_aw_seen", seen, 1);
        ARESETn = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("mid_valids", {AWVALID, WVALID, BREADY}, 0);
        check("mid_busy", busy_o, 0);
        check("mid_cpu", cpu_rst_n_o, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        clear_slave();
        str_q.push_back(32'hE0);
        str_q.push_back(32'hE1);
        begin_load(32'h200, 16'd2);
        wait_done(100, cyc);
        check("fresh_aw", aw_tot - aw0, 2);
        check("fresh_b", b_tot - b0, 2);
        check("fresh_cpu", cpu_rst_n_o, 1);
        check("fresh_err", err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
